// File: rtl/alu_iter.sv
// Iterative ALU: single-cycle ADD/SUB/AND/OR/SLT/NOP, 32-step
// shift-add MUL and restoring DIV on operand magnitudes.
module alu_iter (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] result_o,
  output logic [31:0] hi_o,
  output logic        zero_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        div0_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_SLT = 3'd4;
  localparam logic [2:0] OP_MUL = 3'd5;
  localparam logic [2:0] OP_DIV = 3'd6;
  localparam logic [2:0] OP_NOP = 3'd7;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] mag_q, mag_d;
  logic        neg_q, neg_d;
  logic        rneg_q, rneg_d;
  logic [31:0] result_q, result_d;
  logic [31:0] hi_q, hi_d;
  logic        zero_q, zero_d;
  logic        done_q, done_d;
  logic        div0_q, div0_d;

  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [31:0] alu_res;
  logic [32:0] msum;
  logic [31:0] m_hi, m_lo;
  logic [63:0] prod, prod_s;
  logic [32:0] rsh, rdif;
  logic        d_ok;
  logic [31:0] d_hi, d_lo, quo_s, rem_s;

  assign a_neg = a_i[31];
  assign b_neg = b_i[31];
  assign a_mag = a_neg ? -a_i : a_i;
  assign b_mag = b_neg ? -b_i : b_i;

  // acc:lo is the 64-bit product shifting right; lo starts as |B|
  assign msum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, mag_q} : 33'd0);
  assign m_hi   = msum[32:1];
  assign m_lo   = {msum[0], lo_q[31:1]};
  assign prod   = {m_hi, m_lo};
  assign prod_s = neg_q ? -prod : prod;

  // acc is the partial remainder, lo shifts dividend in and quotient out
  assign rsh   = {acc_q, lo_q[31]};
  assign rdif  = rsh - {1'b0, mag_q};
  assign d_ok  = ~rdif[32];
  assign d_hi  = d_ok ? rdif[31:0] : rsh[31:0];
  assign d_lo  = {lo_q[30:0], d_ok};
  assign quo_s = neg_q ? -d_lo : d_lo;
  assign rem_s = rneg_q ? -d_hi : d_hi;

  always_comb begin
    alu_res = 32'd0;
    unique case (op_i)
      OP_ADD:  alu_res = a_i + b_i;
      OP_SUB:  alu_res = a_i - b_i;
      OP_AND:  alu_res = a_i & b_i;
      OP_OR:   alu_res = a_i | b_i;
      OP_SLT:  alu_res = {31'd0, $signed(a_i) < $signed(b_i)};
      default: alu_res = 32'd0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    mag_d    = mag_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    hi_d     = hi_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    div0_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          cnt_d = 5'd0;
          acc_d = 32'd0;
          neg_d = a_neg ^ b_neg;
          rneg_d = a_neg;
          if (op_i == OP_MUL) begin
            state_d = S_MUL;
            lo_d    = b_mag;
            mag_d   = a_mag;
          end else if (op_i == OP_DIV && b_i != 32'd0) begin
            state_d = S_DIV;
            lo_d    = a_mag;
            mag_d   = b_mag;
          end else if (op_i == OP_DIV) begin
            result_d = 32'hFFFF_FFFF;
            hi_d     = a_i;
            zero_d   = 1'b0;
            done_d   = 1'b1;
            div0_d   = 1'b1;
          end else begin
            result_d = alu_res;
            hi_d     = 32'd0;
            zero_d   = (alu_res == 32'd0);
            done_d   = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_d = m_hi;
        lo_d  = m_lo;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d  = S_IDLE;
          cnt_d    = 5'd0;
          result_d = prod_s[31:0];
          hi_d     = prod_s[63:32];
          zero_d   = (prod_s[31:0] == 32'd0);
          done_d   = 1'b1;
        end
      end
      S_DIV: begin
        acc_d = d_hi;
        lo_d  = d_lo;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d  = S_IDLE;
          cnt_d    = 5'd0;
          result_d = quo_s;
          hi_d     = rem_s;
          zero_d   = (quo_s == 32'd0);
          done_d   = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 5'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      acc_q    <= 32'd0;
      lo_q     <= 32'd0;
      mag_q    <= 32'd0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= 32'd0;
      hi_q     <= 32'd0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      mag_q    <= mag_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
      div0_q   <= div0_d;
    end
  end

  assign result_o = result_q;
  assign hi_o     = hi_q;
  assign zero_o   = zero_q;
  assign busy_o   = (state_q != S_IDLE);
  assign done_o   = done_q;
  assign div0_o   = div0_q;

endmodule

// File: tb/tb_alu_iter.sv
// Scoreboard bench for alu_iter: expectations queued at issue,
// checked on every DONE pulse, plus latency/busy/reset checks.
module tb_alu_iter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic [31:0] result_o, hi_o;
  logic        zero_o, busy_o, done_o, div0_o;

  typedef struct {
    logic [31:0] r;
    logic [31:0] h;
    logic        z;
    logic        d;
    int          lat;
    int          t0;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   errs;
  int   checks;

  alu_iter dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .start_i  (start),
    .op_i     (op),
    .a_i      (a),
    .b_i      (b),
    .result_o (result_o),
    .hi_o     (hi_o),
    .zero_o   (zero_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .div0_o   (div0_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] o,
                                 input logic [31:0] x,
                                 input logic [31:0] y);
    exp_t   e;
    longint sx, sy, p, q, rm;
    sx    = longint'($signed(x));
    sy    = longint'($signed(y));
    e.h   = 32'd0;
    e.d   = 1'b0;
    e.lat = 1;
    e.t0  = 0;
    case (o)
      3'd0: e.r = x + y;
      3'd1: e.r = x - y;
      3'd2: e.r = x & y;
      3'd3: e.r = x | y;
      3'd4: e.r = (sx < sy) ? 32'd1 : 32'd0;
      3'd5: begin
        p     = sx * sy;
        e.r   = p[31:0];
        e.h   = p[63:32];
        e.lat = 33;
      end
      3'd6: begin
        if (y == 32'd0) begin
          e.r = 32'hFFFF_FFFF;
          e.h = x;
          e.d = 1'b1;
        end else begin
          q     = sx / sy;
          rm    = sx % sy;
          e.r   = q[31:0];
          e.h   = rm[31:0];
          e.lat = 33;
        end
      end
      default: e.r = 32'd0;
    endcase
    e.z = (o == 3'd6 && y == 32'd0) ? 1'b0 : (e.r == 32'd0);
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && done_o) begin
      if (sb.size() == 0) begin
        chk("extra_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result_o, e.r);
        chk("hi", hi_o, e.h);
        chk("zero", zero_o, e.z);
        chk("div0", div0_o, e.d);
        chk("latency", cyc - e.t0, e.lat);
        chk("busy_at_done", busy_o, 0);
      end
    end
  end

  // Drive at negedge+1; returns in the cycle after E0 with inputs scrambled
  task automatic go(input logic [2:0] o,
                    input logic [31:0] x,
                    input logic [31:0] y);
    exp_t e;
    e    = model(o, x, y);
    e.t0 = cyc;
    sb.push_back(e);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clk);
    #1;
    start = 1'b0;
    op    = 3'($urandom);
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 50; k++) begin
      if (!busy_o && !done_o && sb.size() == 0) return;
      @(negedge clk);
      #1;
    end
    chk("timeout", 1, 0);
  endtask

  initial begin
    int n;
    logic [2:0] ro;
    logic [31:0] ra, rb;
    errs   = 0;
    checks = 0;
    cyc    = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    op     = 3'd0;
    a      = 32'd0;
    b      = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_result", result_o, 0);
    chk("rst_hi", hi_o, 0);
    chk("rst_flags", {zero_o, busy_o, done_o, div0_o}, 0);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    #1;

    go(3'd0, 32'd5, 32'd7);
    wait_idle();
    go(3'd1, 32'd9, 32'd9);
    wait_idle();
    go(3'd4, 32'hFFFF_FFFF, 32'd1);
    wait_idle();
    go(3'd7, 32'h1234, 32'h5678);
    wait_idle();

    go(3'd5, -32'sd3, 32'd7);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (!busy_o) break;
      n++;
      start = (k == 4);
      op    = 3'd0;
      a     = 32'd1;
      b     = 32'd1;
      @(negedge clk);
      #1;
    end
    start = 1'b0;
    chk("mul_busy_cycles", n, 32);
    wait_idle();

    go(3'd2, 32'hF0F0_1234, 32'h0FF0_FFFF);
    wait_idle();
    go(3'd6, -32'sd7, 32'd2);
    wait_idle();
    go(3'd6, 32'd10, 32'd0);
    chk("div0_busy", busy_o, 0);
    wait_idle();

    go(3'd5, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (10) begin
      @(negedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("arst_result", result_o, 0);
    chk("arst_hi", hi_o, 0);
    chk("arst_flags", {zero_o, busy_o, done_o, div0_o}, 0);
    repeat (3) @(negedge clk);
    chk("arst_hold", {busy_o, done_o}, 0);
    #1;
    rst_n = 1'b1;
    go(3'd0, 32'd1, 32'd1);
    wait_idle();

    go(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    for (int k = 0; k < 40; k++) begin
      if (done_o) break;
      @(negedge clk);
      #1;
    end
    chk("b2b_done_seen", done_o, 1);
    go(3'd2, 32'hFFFF_0000, 32'h00FF_FF00);
    wait_idle();

    for (int i = 0; i < 14; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (i % 5 == 4) ? 32'd0 : $urandom;
      if (i % 3 == 0) rb = 32'($urandom_range(1, 20)) - 32'd10;
      go(ro, ra, rb);
      wait_idle();
    end

    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/alu_iter.md
ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset; ports are listed below.
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 RST_N  input  1  asynchronous active-low reset.
REQ-004 START  input  1  request to run one operation; sampled only when BUSY=0.
REQ-005 OP  input  3  operation code from the ALU control decoder: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 MUL, 6 DIV, 7 NOP.
REQ-006 A  input  32  operand A, two's complement.
REQ-007 B  input  32  operand B, two's complement.
REQ-008 RESULT  output  32  result, or product LO, or quotient; held until the next completion.
REQ-009 HI  output  32  product HI or remainder; cleared by single-cycle ops.
REQ-010 ZERO  output  1  set when RESULT=0; updated together with RESULT.
REQ-011 BUSY  output  1  set while a MUL/DIV iteration is in progress.
REQ-012 DONE  output  1  one-cycle pulse marking a valid RESULT/HI/ZERO.
REQ-013 DIV0  output  1  set with DONE when a DIV had B=0; otherwise 0 at every DONE.

Function
REQ-014 Define E0 as the rising edge at which START=1 and BUSY=0; A, B and OP SHALL be latched at E0 and later input changes SHALL be ignored.
REQ-015 State machine: IDLE, MUL, DIV; IDLE->MUL on OP=5, IDLE->DIV on OP=6 with B!=0, stay IDLE otherwise; MUL/DIV->IDLE after iteration 32.
REQ-016 OP 0-4, 7 and DIV with B=0 SHALL complete at E0: outputs registered at E0, DONE=1 for the cycle after E0, BUSY stays 0.
REQ-017 ADD/SUB SHALL wrap modulo 2^32; no overflow flag.
REQ-018 AND/OR SHALL be bitwise; SLT SHALL give RESULT=1 if A<B signed, else 0.
REQ-019 NOP SHALL give RESULT=0, HI=0, ZERO=1.
REQ-020 MUL SHALL be a signed 32x32->64 shift-add on magnitudes with final sign correction; RESULT=product[31:0], HI=product[63:32].
REQ-021 DIV SHALL be restoring division on magnitudes; quotient sign = sign(A) xor sign(B), remainder sign = sign(A); RESULT=quotient, HI=remainder.
REQ-022 DIV 0x80000000 / 0xFFFFFFFF SHALL give RESULT=0x80000000, HI=0.
REQ-023 DIV with B=0 SHALL give RESULT=0xFFFFFFFF, HI=A, DIV0=1, single-cycle.
REQ-024 MUL/DIV: BUSY=1 from E0 through E32; one iteration at each edge E1..E32; final corrected outputs registered at E32; DONE=1 and BUSY=0 for the cycle after E32.
REQ-025 A 5-bit iteration counter SHALL count 0..31 and clear on return to IDLE.
REQ-026 START while BUSY=1 SHALL be ignored, with no queuing.
REQ-027 START in the DONE cycle SHALL be accepted, so back-to-back operations run with no gap.
REQ-028 RESULT, HI and ZERO SHALL change only on a completion edge or at reset; intermediate values SHALL stay in internal registers.

Reset
REQ-029 While RST_N=0, regardless of CLK, the block SHALL hold state IDLE and counter 0, with RESULT=0, HI=0, ZERO=0, BUSY=0, DONE=0, DIV0=0.
REQ-030 Reset during MUL/DIV SHALL abandon the operation without a DONE pulse.
REQ-031 After RST_N rises, the first START SHALL be handled normally.

Verification
REQ-032 ADD A=5, B=7 -> cycle after E0: DONE=1, RESULT=12, HI=0, ZERO=0, BUSY=0.
REQ-033 SUB A=9, B=9 -> RESULT=0, ZERO=1; then SLT A=0xFFFFFFFF, B=1 -> RESULT=1.
REQ-034 MUL A=-3, B=7 -> BUSY=1 for 32 cycles; after E32: DONE=1, RESULT=0xFFFFFFEB, HI=0xFFFFFFFF; a START at E5 with OP=0 is ignored.
REQ-035 DIV A=-7, B=2 -> after E32: RESULT=0xFFFFFFFD, HI=0xFFFFFFFF, DIV0=0; DIV A=10, B=0 -> cycle after E0: DONE=1, DIV0=1, RESULT=0xFFFFFFFF, HI=10.
REQ-036 RST_N low mid-cycle after E10 of a MUL -> all outputs 0 immediately, with no DONE; after release, ADD A=1, B=1 -> RESULT=2.
REQ-037 DIV A=0x80000000, B=-1, followed by a START with OP=2 in the DONE cycle -> RESULT=0x80000000, HI=0; the AND completes in the next cycle.
